// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO: DEPTH (pc, inst) entries between fetch and decode, valid/ready on both sides.
// Define IF_ID_QUEUE_BYPASS_EN to forward fetch straight to decode through an empty queue.
module if_id_queue #(
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush_i,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic [INST_W-1:0] if_inst_i,
    output logic              if_ready_o,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    input  logic              id_ready_i,
    output logic [PTR_W:0]    count_o
);

    localparam int DEPTH = 2 ** PTR_W;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic active, head_valid, bypass, push, pop;

    assign active     = rdy && !rst;
    assign head_valid = active && (count != '0);
    assign if_ready_o = active && (count < FULL);

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass = active && (count == '0) && if_valid_i && id_ready_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry is consumed on the spot, so it must not also be written.
    assign push = if_valid_i && if_ready_o && !flush_i && !bypass;
    assign pop  = head_valid && id_ready_i && !flush_i;

    // NOTE: every variable gets a default first so the mux cannot infer a latch.
    always_comb begin
        id_valid_o = 1'b0;
        id_pc_o    = '0;
        id_inst_o  = '0;
        if (head_valid) begin
            id_valid_o = 1'b1;
            id_pc_o    = pc_mem[rd_ptr];
            id_inst_o  = inst_mem[rd_ptr];
        end else if (bypass) begin
            id_valid_o = 1'b1;
            id_pc_o    = if_pc_i;
            id_inst_o  = if_inst_i;
        end
    end

    assign count_o = count;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy) begin
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= if_pc_i;
            inst_mem[wr_ptr] <= if_inst_i;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed, table-driven bench for if_id_queue; inputs applied on the falling edge, outputs checked 1 ns later.
// Covers fill/full, drain, streaming with wrap, flush, rdy freeze, bypass (either build) and async reset.
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        flush_i = 1'b0;
    logic        if_valid_i = 1'b0;
    logic [31:0] if_pc_i = '0;
    logic [31:0] if_inst_i = '0;
    logic        if_ready_o;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i = 1'b0;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    if_id_queue #(.PTR_W(2), .ADDR_W(32), .INST_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_inst_i  (if_inst_i),
        .if_ready_o (if_ready_o),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_ready_i (id_ready_i),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    typedef struct {
        logic        rst, rdy, flush, valid, id_ready;
        logic [31:0] pc;
        logic        e_ifr, e_idv;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Each fetched instruction is ~pc, so an expected head pc implies its instruction.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return ~pc;
    endfunction

    task automatic add(input logic r, rd, fl, v, idr, input logic [31:0] pc,
                       input logic e_ifr, e_idv, input logic [31:0] e_pc, input logic [2:0] e_cnt);
        vec_t t;
        t.rst = r; t.rdy = rd; t.flush = fl; t.valid = v; t.id_ready = idr; t.pc = pc;
        t.e_ifr = e_ifr; t.e_idv = e_idv; t.e_pc = e_pc; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, rd, fl, v, idr, input logic [31:0] pc, input logic [31:0] inst);
        rst = r; rdy = rd; flush_i = fl; if_valid_i = v; id_ready_i = idr;
        if_pc_i = pc; if_inst_i = inst;
    endtask

    initial begin
        //   rst rdy fl  v  idr  pc          ifr idv head pc      cnt
        add(1, 1, 0, 1, 0, 32'h100,   0, 0, 32'h0,   3'd0);   // in reset
        add(0, 1, 0, 1, 0, 32'h100,   1, 0, 32'h0,   3'd0);   // fill
        add(0, 1, 0, 1, 0, 32'h104,   1, 1, 32'h100, 3'd1);
        add(0, 1, 0, 1, 0, 32'h108,   1, 1, 32'h100, 3'd2);
        add(0, 1, 0, 1, 0, 32'h10C,   1, 1, 32'h100, 3'd3);
        add(0, 1, 0, 1, 0, 32'h110,   0, 1, 32'h100, 3'd4);   // full, 0x110 refused
        add(0, 1, 0, 1, 1, 32'h110,   0, 1, 32'h100, 3'd4);   // full even while popping
        add(0, 1, 0, 0, 1, 32'h0,     1, 1, 32'h104, 3'd3);   // drain
        add(0, 1, 0, 0, 1, 32'h0,     1, 1, 32'h108, 3'd2);
        add(0, 1, 0, 0, 1, 32'h0,     1, 1, 32'h10C, 3'd1);
        add(0, 1, 0, 0, 1, 32'h0,     1, 0, 32'h0,   3'd0);   // empty ignores id_ready
        add(0, 1, 0, 1, 0, 32'h200,   1, 0, 32'h0,   3'd0);   // streaming, wraps pointers
        for (int k = 1; k < 10; k++)
            add(0, 1, 0, 1, 1, 32'h200 + 32'(4 * k), 1, 1, 32'h200 + 32'(4 * (k - 1)), 3'd1);
        add(0, 1, 0, 0, 1, 32'h0,     1, 1, 32'h224, 3'd1);
        add(0, 1, 0, 0, 0, 32'h0,     1, 0, 32'h0,   3'd0);
        add(0, 1, 0, 1, 0, 32'h240,   1, 0, 32'h0,   3'd0);   // build count 3
        add(0, 1, 0, 1, 0, 32'h244,   1, 1, 32'h240, 3'd1);
        add(0, 1, 0, 1, 0, 32'h248,   1, 1, 32'h240, 3'd2);
        add(0, 1, 1, 1, 0, 32'h300,   1, 1, 32'h240, 3'd3);   // flush drops 0x300
        add(0, 1, 0, 1, 0, 32'h400,   1, 0, 32'h0,   3'd0);
        add(0, 1, 0, 0, 0, 32'h0,     1, 1, 32'h400, 3'd1);
        add(0, 1, 0, 1, 0, 32'h404,   1, 1, 32'h400, 3'd1);
        for (int k = 0; k < 3; k++)                           // rdy freeze
            add(0, 0, 1, 1, 1, 32'h500, 0, 0, 32'h0, 3'd2);
        add(0, 1, 0, 0, 0, 32'h0,     1, 1, 32'h400, 3'd2);
        add(0, 1, 0, 0, 1, 32'h0,     1, 1, 32'h400, 3'd2);
        add(0, 1, 0, 0, 1, 32'h0,     1, 1, 32'h404, 3'd1);
        add(0, 1, 0, 0, 0, 32'h0,     1, 0, 32'h0,   3'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].flush, vecs[i].valid, vecs[i].id_ready,
                  vecs[i].pc, inst_of(vecs[i].pc));
            #1;
            check($sformatf("vec%0d status{ifr,idv,cnt}", i),
                  64'({if_ready_o, id_valid_o, count_o}),
                  64'({vecs[i].e_ifr, vecs[i].e_idv, vecs[i].e_cnt}));
            check($sformatf("vec%0d id_pc", i), 64'(id_pc_o), 64'(vecs[i].e_pc));
            check($sformatf("vec%0d id_inst", i), 64'(id_inst_o),
                  64'(vecs[i].e_idv ? inst_of(vecs[i].e_pc) : 32'h0));
        end

        // Fetch into an empty queue with decode ready.
        @(negedge clk);
        drive(0, 1, 0, 1, 1, 32'h500, 32'h0000_0013);
        #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
        check("bypass id_valid", 64'(id_valid_o), 64'd1);
        check("bypass id_pc", 64'(id_pc_o), 64'h500);
        check("bypass id_inst", 64'(id_inst_o), 64'h13);
        check("bypass count", 64'(count_o), 64'd0);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        #1;
        check("bypass not stored count", 64'(count_o), 64'd0);
        check("bypass not stored valid", 64'(id_valid_o), 64'd0);
`else
        check("nobypass id_valid", 64'(id_valid_o), 64'd0);
        check("nobypass id_pc", 64'(id_pc_o), 64'h0);
        @(negedge clk);
        drive(0, 1, 0, 0, 1, 32'h0, 32'h0);
        #1;
        check("late id_valid", 64'(id_valid_o), 64'd1);
        check("late id_pc", 64'(id_pc_o), 64'h500);
        check("late id_inst", 64'(id_inst_o), 64'h13);
        check("late count", 64'(count_o), 64'd1);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        #1;
        check("late drained", 64'(count_o), 64'd0);
`endif

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        drive(0, 1, 0, 1, 0, 32'h600, inst_of(32'h600));
        @(negedge clk);
        drive(0, 1, 0, 1, 0, 32'h604, inst_of(32'h604));
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        #1;
        check("pre-reset count", 64'(count_o), 64'd2);
        check("pre-reset head", 64'(id_pc_o), 64'h600);
        rst = 1'b1;
        #1;
        check("async reset status{ifr,idv,cnt}", 64'({if_ready_o, id_valid_o, count_o}), 64'd0);
        check("async reset id_pc", 64'(id_pc_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset status{ifr,idv,cnt}", 64'({if_ready_o, id_valid_o, count_o}),
              64'({1'b1, 1'b0, 3'd0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID register: a DEPTH-entry FIFO carrying (pc, inst) pairs from fetch to decode.
- Uses valid/ready handshakes on both sides, so fetch can run ahead while decode stalls.
- Misprediction flush empties the queue in one cycle.
- Sits between the IF stage and the ID stage; decode sees a zero bubble when the queue is empty.

Parameters:
- PTR_W, 2, pointer width; queue depth DEPTH = 2**PTR_W (derived localparam, default 4).
- ADDR_W, 32, pc width.
- INST_W, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rdy  input  1  global ready; when 0, all state frozen.
- flush_i  input  1  jump-mispredict flush from EX; discards all queued entries.
- if_valid_i  input  1  fetch presents a valid instruction.
- if_pc_i  input  ADDR_W  fetched pc.
- if_inst_i  input  INST_W  fetched instruction.
- if_ready_o  output  1  queue can accept an entry this cycle.
- id_valid_o  output  1  head entry valid for decode.
- id_pc_o  output  ADDR_W  head pc; zero when id_valid_o=0.
- id_inst_o  output  INST_W  head instruction; zero when id_valid_o=0.
- id_ready_i  input  1  decode consumes the head this cycle (decode not stalled).
- count_o  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- State:
  - wr_ptr, rd_ptr: PTR_W bits, wrap modulo DEPTH.
  - count: PTR_W+1 bits.
  - storage array pc_mem[DEPTH], inst_mem[DEPTH].
- Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0. Outputs: if_ready_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0. Storage contents don't-care.
- Combinational outputs:
  - if_ready_o = rdy && !rst && count<DEPTH.
  - id_valid_o = rdy && !rst && count!=0.
  - id_pc_o/id_inst_o = head entry when id_valid_o, else all-zero (bubble = nop, pc 0).
  - count_o = count.
- push = if_valid_i && if_ready_o && !flush_i.
- pop = id_valid_o && id_ready_i && !flush_i.
- Clock edge, rdy=1, priority order:
  1. flush_i=1: wr_ptr=rd_ptr=0, count=0. Same-cycle push and pop both ignored; the entry presented by fetch is dropped.
  2. Otherwise:
     - push writes mem[wr_ptr] and increments wr_ptr.
     - pop increments rd_ptr.
     - count += push − pop; simultaneous push and pop leaves count unchanged.
- Clock edge, rdy=0: no state change, flush_i included (held until rdy returns).
- Latency: an entry pushed at edge N is visible on id_* after edge N (one cycle, fetch to decode).
- Full (count=DEPTH): if_ready_o=0, even if decode pops that cycle; no full-bypass push.
- Empty (count=0): id_valid_o=0, outputs zero, id_ready_i ignored.
- Wrap-around: pointers roll DEPTH-1 → 0 with no gap or loss.
- Reset mid-operation clears immediately, regardless of clk or rdy.
- Ordering: strict FIFO, no reordering, no duplication.

Optional Feature:
- Macro: IF_ID_QUEUE_BYPASS_EN.
- Defined:
  - When count=0, if_valid_i=1, id_ready_i=1, rdy=1 and flush_i=0, the fetch entry drives id_* combinationally in the same cycle: id_valid_o=1, id_pc_o=if_pc_i, id_inst_o=if_inst_i.
  - The entry is consumed and not written to storage; pointers and count unchanged.
  - Gives zero-cycle latency through an empty queue.
- Undefined:
  - No bypass; minimum latency one cycle as above.
  - id_* depend only on registered state.

Test Plan:
- Reset then fill: rst pulse; push pc=0x100,0x104,0x108,0x10C with id_ready_i=0 → count_o=4, if_ready_o=0 after 4th edge. 5th push pc=0x110 is not accepted.
- Drain in order: from full, id_ready_i=1 for 4 cycles → id_pc_o sequence 0x100,0x104,0x108,0x10C, then id_valid_o=0, id_pc_o=0, id_inst_o=0.
- Steady streaming with wrap:
  - Continuous push and pop for 10 entries (pc 0x200+4k) → count_o constant 1, every pc appears exactly once in order.
  - Pointers wrap past 3 with no loss.
- Flush with simultaneous push: count=3, assert flush_i with if_valid_i=1, pc=0x300 → next cycle count_o=0, id_valid_o=0. Following push 0x400 emerges next, not 0x300.
- rdy freeze: count=2, rdy=0 for 3 cycles with flush_i=1 and id_ready_i=1 → count_o stays 2, if_ready_o=0, id_valid_o=0. After rdy=1 with flush_i=0, head pc is unchanged.
- Bypass (IF_ID_QUEUE_BYPASS_EN): empty queue, if_valid_i=1 pc=0x500 inst=0x00000013, id_ready_i=1 → same cycle id_valid_o=1, id_pc_o=0x500, count_o stays 0. Without the macro, id_valid_o=0 that cycle and pc 0x500 appears one cycle later.
